// File: rtl/mode_message_scroller.sv
// Registered mode-to-7-seg message driver: right-aligned static text, left scroll with wrap-around
// for messages wider than the display, and a blinking ALARM message. Digit 0 is the leftmost digit.
module mode_message_scroller #(
  parameter int NUM_DIGITS   = 6,
  parameter int MSG_BITS     = 4,
  parameter int STEP_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              mode,
  input  logic [MSG_BITS-1:0]     msg,
  input  logic                    blank,
  output logic [7*NUM_DIGITS-1:0] display,
  output logic                    scroll_wrap
);

  localparam logic [6:0] G_A    = 7'b0001000;
  localparam logic [6:0] G_E    = 7'b0000110;
  localparam logic [6:0] G_L    = 7'b1000111;
  localparam logic [6:0] G_M    = 7'b0101011;
  localparam logic [6:0] G_N    = 7'b1001000;
  localparam logic [6:0] G_R    = 7'b0101111;
  localparam logic [6:0] G_S    = 7'b0010010;
  localparam logic [6:0] G_T    = 7'b0000111;
  localparam logic [6:0] G_U    = 7'b1000001;
  localparam logic [6:0] G_ONE  = 7'b1111001;
  localparam logic [6:0] G_ZERO = 7'b1000000;
  localparam logic [6:0] G_OFF  = 7'b1111111;

  localparam logic [2:0]  M_RESET   = 3'd3;
  localparam logic [2:0]  M_DISPLAY = 3'd4;
  localparam logic [2:0]  M_ALARM   = 3'd5;
  localparam logic [31:0] STEP_LAST  = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

  // Message length in glyphs; zero for the blank modes.
  function automatic logic [4:0] msg_len(input logic [2:0] m);
    logic [4:0] len;
    case (m)
      3'd0, 3'd1, 3'd2, M_ALARM: len = 5'd6;
      M_RESET:                   len = 5'd5;
      M_DISPLAY:                 len = 5'(MSG_BITS);
      default:                   len = 5'd0;
    endcase
    return len;
  endfunction

  // Glyph at position p of the message string; positions past the end read as OFF.
  function automatic logic [6:0] glyph_at(input logic [2:0] m, input logic [4:0] p,
                                          input logic [MSG_BITS-1:0] bits);
    logic [6:0] g;
    g = G_OFF;
    case (m)
      3'd0: begin
        case (p)
          5'd0:       g = G_U;
          5'd1:       g = G_N;
          5'd2:       g = G_A;
          5'd3:       g = G_R;
          5'd4, 5'd5: g = G_M;
          default:    g = G_OFF;
        endcase
      end
      3'd1, 3'd2: begin
        case (p)
          5'd0:       g = G_A;
          5'd1:       g = G_R;
          5'd2, 5'd3: g = G_M;
          5'd5:       g = (m == 3'd1) ? G_S : G_A;
          default:    g = G_OFF;
        endcase
      end
      M_RESET: begin
        case (p)
          5'd0:       g = G_R;
          5'd1, 5'd3: g = G_E;
          5'd2:       g = G_S;
          5'd4:       g = G_T;
          default:    g = G_OFF;
        endcase
      end
      M_ALARM: begin
        case (p)
          5'd0, 5'd2: g = G_A;
          5'd1:       g = G_L;
          5'd3:       g = G_R;
          5'd4, 5'd5: g = G_M;
          default:    g = G_OFF;
        endcase
      end
      M_DISPLAY: begin
        // Most significant passcode bit is the first glyph.
        for (int i = 0; i < MSG_BITS; i++) begin
          if (p == 5'(i)) begin
            g = bits[MSG_BITS-1-i] ? G_ONE : G_ZERO;
          end else begin
            g = g;
          end
        end
      end
      default: g = G_OFF;
    endcase
    return g;
  endfunction

  // Glyph for digit k at scroll index ix: ring walk when scrolling, right-aligned otherwise.
  function automatic logic [6:0] digit_glyph(input logic [2:0] m, input logic [3:0] ix,
                                             input logic [4:0] k, input logic [MSG_BITS-1:0] bits);
    logic [4:0] len;
    logic [4:0] raw;
    logic [4:0] pos;
    logic [4:0] lead;
    logic [6:0] g;
    len = msg_len(m);
    if (len > 5'(NUM_DIGITS)) begin
      // Ring period is len+1 (trailing OFF gap); idx+k never reaches two periods.
      raw = {1'b0, ix} + k;
      if (raw > len) begin
        pos = raw - (len + 5'd1);
      end else begin
        pos = raw;
      end
      g = glyph_at(m, pos, bits);
    end else begin
      lead = 5'(NUM_DIGITS) - len;
      if (k >= lead) begin
        g = glyph_at(m, k - lead, bits);
      end else begin
        g = G_OFF;
      end
    end
    return g;
  endfunction

  logic [2:0]              mode_q_r;
  logic [3:0]              idx_r;
  logic [31:0]             step_r;
  logic [31:0]             blink_cnt_r;
  logic                    blink_on_r;
  logic [7*NUM_DIGITS-1:0] display_r;
  logic                    scroll_wrap_r;

  logic [4:0]              len_s;
  logic                    scroll_s;
  logic                    mode_chg_s;
  logic [3:0]              idx_n_s;
  logic [31:0]             step_n_s;
  logic [31:0]             blink_cnt_n_s;
  logic                    blink_on_n_s;
  logic                    wrap_n_s;
  logic [7*NUM_DIGITS-1:0] frame_s;
  logic [7*NUM_DIGITS-1:0] display_n_s;

  // Next-state of the scroll index, step counter and blink phase.
  always_comb begin
    len_s         = msg_len(mode);
    scroll_s      = (len_s > 5'(NUM_DIGITS));
    mode_chg_s    = (mode != mode_q_r);
    idx_n_s       = idx_r;
    step_n_s      = step_r;
    blink_cnt_n_s = blink_cnt_r;
    blink_on_n_s  = blink_on_r;
    wrap_n_s      = 1'b0;
    if (mode_chg_s) begin
      idx_n_s       = 4'd0;
      step_n_s      = 32'd0;
      blink_cnt_n_s = 32'd0;
      blink_on_n_s  = 1'b1;
    end else begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_n_s = 32'd0;
        blink_on_n_s  = ~blink_on_r;
      end else begin
        blink_cnt_n_s = blink_cnt_r + 32'd1;
      end
      if (!scroll_s) begin
        idx_n_s  = 4'd0;
        step_n_s = 32'd0;
      end else if (step_r == STEP_LAST) begin
        step_n_s = 32'd0;
        if (idx_r == len_s[3:0]) begin
          idx_n_s  = 4'd0;
          wrap_n_s = 1'b1;
        end else begin
          idx_n_s = idx_r + 4'd1;
        end
      end else begin
        step_n_s = step_r + 32'd1;
      end
    end
  end

  // Frame for the state being entered, so every input change shows after exactly one edge.
  always_comb begin
    frame_s = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      frame_s[7*(NUM_DIGITS-1-k) +: 7] = digit_glyph(mode, idx_n_s, 5'(k), msg);
    end
    if (blank) begin
      display_n_s = '1;
    end else if ((mode == M_ALARM) && !blink_on_n_s) begin
      display_n_s = '1;
    end else begin
      display_n_s = frame_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q_r      <= 3'd0;
      idx_r         <= 4'd0;
      step_r        <= 32'd0;
      blink_cnt_r   <= 32'd0;
      blink_on_r    <= 1'b1;
      display_r     <= '1;
      scroll_wrap_r <= 1'b0;
    end else begin
      mode_q_r      <= mode;
      idx_r         <= idx_n_s;
      step_r        <= step_n_s;
      blink_cnt_r   <= blink_cnt_n_s;
      blink_on_r    <= blink_on_n_s;
      display_r     <= display_n_s;
      scroll_wrap_r <= wrap_n_s;
    end
  end

  assign display     = display_r;
  assign scroll_wrap = scroll_wrap_r;

endmodule

// File: tb/tb_mode_message_scroller.sv
// Scoreboard bench for mode_message_scroller: stimulus queues cycle-stamped expected frames,
// a negedge monitor pops and compares them against display/scroll_wrap.
module tb_mode_message_scroller;

  localparam logic [6:0] A = 7'b0001000, E = 7'b0000110, L = 7'b1000111, M = 7'b0101011;
  localparam logic [6:0] N = 7'b1001000, R = 7'b0101111, S = 7'b0010010, T = 7'b0000111;
  localparam logic [6:0] U = 7'b1000001, I = 7'b1111001, Z = 7'b1000000, O = 7'b1111111;
  localparam logic [27:0] OFF = 28'hFFFFFFF;

  typedef struct {
    int          cyc;
    logic [27:0] disp;
    logic        wrap;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode;
  logic [3:0]  msg;
  logic        blank;
  logic [27:0] display;
  logic        scroll_wrap;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [27:0] unarm_f [7];
  logic [27:0] arms_f  [3];
  logic [27:0] alarm_f [7];
  logic [27:0] reset_f [6];

  mode_message_scroller #(
    .NUM_DIGITS(4), .MSG_BITS(4), .STEP_CYCLES(4), .BLINK_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .msg(msg), .blank(blank),
    .display(display), .scroll_wrap(scroll_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc_cnt) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d examined at cycle %0d", mon_e.name, mon_e.cyc, cyc_cnt);
      end else if (display !== mon_e.disp || scroll_wrap !== mon_e.wrap) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): display=%h scroll_wrap=%b, required display=%h scroll_wrap=%b",
                 mon_e.name, cyc_cnt, display, scroll_wrap, mon_e.disp, mon_e.wrap);
      end
    end
  end

  function automatic logic [27:0] f4(input logic [6:0] g0, input logic [6:0] g1,
                                     input logic [6:0] g2, input logic [6:0] g3);
    return {g0, g1, g2, g3};
  endfunction

  // Expectation for the current cycle (outputs not dependent on a clock edge).
  task automatic push_now(input logic [27:0] ed, input logic ew, input string nm);
    exp_t e;
    e.cyc = cyc_cnt; e.disp = ed; e.wrap = ew; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Apply inputs for one cycle and queue the response expected after the next edge.
  task automatic drive(input logic [2:0] m, input logic [3:0] ms, input logic bl,
                       input logic [27:0] ed, input logic ew, input string nm);
    exp_t e;
    mode = m; msg = ms; blank = bl;
    e.cyc = cyc_cnt + 1; e.disp = ed; e.wrap = ew; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    unarm_f = '{f4(U,N,A,R), f4(N,A,R,M), f4(A,R,M,M), f4(R,M,M,O),
                f4(M,M,O,U), f4(M,O,U,N), f4(O,U,N,A)};
    arms_f  = '{f4(A,R,M,M), f4(R,M,M,O), f4(M,M,O,S)};
    alarm_f = '{f4(A,L,A,R), f4(L,A,R,M), f4(A,R,M,M), f4(R,M,M,O),
                f4(M,M,O,A), f4(M,O,A,L), f4(O,A,L,A)};
    reset_f = '{f4(R,E,S,E), f4(E,S,E,T), f4(S,E,T,O), f4(E,T,O,R),
                f4(T,O,R,E), f4(O,R,E,S)};

    reset_n = 1'b0; mode = 3'd3; msg = 4'd0; blank = 1'b0;
    @(posedge clk); #1;
    push_now(OFF, 1'b0, "reset_state");
    @(posedge clk); #1;
    push_now(OFF, 1'b0, "reset_state_held");
    reset_n = 1'b1;
    drive(3'd6, 4'd0, 1'b0, OFF, 1'b0, "mode6_off");
    drive(3'd7, 4'd0, 1'b0, OFF, 1'b0, "mode7_off");

    for (int c = 0; c < 32; c++)
      drive(3'd0, 4'd0, 1'b0, unarm_f[(c/4)%7], (c == 28), "unarm_scroll");

    // The first drive lands on a step terminal count of the UNARM scroll.
    for (int c = 0; c < 12; c++)
      drive(3'd1, 4'd0, 1'b0, arms_f[c/4], 1'b0, "modechg_arms");

    for (int u = 0; u < 24; u++) begin
      if (u >= 6 && u < 16) drive(3'd0, 4'd0, 1'b1, OFF, 1'b0, "blank_unarm");
      else                  drive(3'd0, 4'd0, 1'b0, unarm_f[(u/4)%7], 1'b0, "blank_release_unarm");
    end

    for (int d = 0; d < 6; d++)
      drive(3'd4, 4'b1010, 1'b0, f4(I,Z,I,Z), 1'b0, "display_1010");
    for (int d = 0; d < 6; d++)
      drive(3'd4, 4'b0001, 1'b0, f4(Z,Z,Z,I), 1'b0, "display_0001");
    drive(3'd4, 4'b1100, 1'b0, f4(I,I,Z,Z), 1'b0, "display_1100");
    drive(3'd4, 4'b1100, 1'b1, OFF, 1'b0, "display_blank");
    drive(3'd4, 4'b0111, 1'b0, f4(Z,I,I,I), 1'b0, "display_0111");

    for (int a = 0; a < 25; a++)
      drive(3'd5, 4'd0, 1'b0, (((a/3)%2) == 0) ? alarm_f[(a/4)%7] : OFF, 1'b0, "alarm_blink");

    // Mid-scroll asynchronous reset, checked before the next clock edge.
    @(posedge clk); #1;
    push_now(OFF, 1'b0, "reset_async");
    #1 reset_n = 1'b0;
    mode = 3'd3;
    @(posedge clk); #1;
    push_now(OFF, 1'b0, "reset_async_held");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int r = 0; r < 26; r++)
      drive(3'd3, 4'd0, 1'b0, reset_f[(r/4)%6], (r == 24), "reset_release_rese");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
